// File: rtl/vec_mux_pipe.sv
// K-input vector mux with per-lane zero mask, registered behind a 2-entry skid buffer.
// Latency 1 cycle; in_ready (registered) drops only when the skid entry is occupied.
// Optional per-lane vector select: define VEC_MUX_LANE_SEL_EN.
module vec_mux_pipe #(
   parameter int N  = 16,
   parameter int M  = 16,
   parameter int K  = 3,
   parameter int SW = (K > 1) ? $clog2(K) : 1,
   parameter int CW = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [K*M*N-1:0]   in_data,
   input  logic [SW-1:0]      in_sel,
   input  logic [M-1:0]       in_lane_mask,
`ifdef VEC_MUX_LANE_SEL_EN
   input  logic [M*SW-1:0]    in_lane_sel,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [M*N-1:0]     out_data,
   output logic               out_sel_err,
   output logic [CW-1:0]      err_count
);

   // One extra bit so K itself is representable when K is a power of two.
   localparam logic [SW:0] K_L = (SW+1)'(K);

   logic [M*N-1:0] res_dat;
   logic           res_err;
   logic [SW-1:0]  lane_sel;

   logic           main_vld_q, main_vld_d;
   logic [M*N-1:0] main_dat_q, main_dat_d;
   logic           main_err_q, main_err_d;
   logic           skid_vld_q, skid_vld_d;
   logic [M*N-1:0] skid_dat_q, skid_dat_d;
   logic           skid_err_q, skid_err_d;
   logic [CW-1:0]  err_cnt_q, err_cnt_d;

   logic accept;
   logic xfer;

`ifdef VEC_MUX_LANE_SEL_EN
   logic unused_in_sel;
   assign unused_in_sel = ^in_sel;
`endif

   // An out-of-range select matches no vector, so that lane falls through to zero.
   always_comb begin
      res_dat  = '0;
      res_err  = 1'b0;
      lane_sel = '0;
      for (int m = 0; m < M; m++) begin
`ifdef VEC_MUX_LANE_SEL_EN
         lane_sel = in_lane_sel[m*SW +: SW];
`else
         lane_sel = in_sel;
`endif
         if ({1'b0, lane_sel} >= K_L) begin
            res_err = 1'b1;
         end
         for (int k = 0; k < K; k++) begin
            if (lane_sel == SW'(k) && in_lane_mask[m]) begin
               res_dat[m*N +: N] = in_data[k*M*N + m*N +: N];
            end
         end
      end
   end

   assign in_ready = !skid_vld_q;
   assign accept   = in_valid && in_ready;
   assign xfer     = main_vld_q && out_ready;

   always_comb begin
      main_vld_d = main_vld_q;
      main_dat_d = main_dat_q;
      main_err_d = main_err_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      skid_err_d = skid_err_q;
      err_cnt_d  = err_cnt_q;

      if (accept) begin
         if (!main_vld_q || out_ready) begin
            main_vld_d = 1'b1;
            if (skid_vld_q) begin
               // Older skid entry advances; new result takes its place.
               main_dat_d = skid_dat_q;
               main_err_d = skid_err_q;
               skid_dat_d = res_dat;
               skid_err_d = res_err;
            end else begin
               main_dat_d = res_dat;
               main_err_d = res_err;
            end
         end else begin
            skid_vld_d = 1'b1;
            skid_dat_d = res_dat;
            skid_err_d = res_err;
         end
         if (res_err && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CW'(1);
         end
      end else if (xfer) begin
         if (skid_vld_q) begin
            main_dat_d = skid_dat_q;
            main_err_d = skid_err_q;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld_q <= 1'b0;
         main_dat_q <= '0;
         main_err_q <= 1'b0;
         skid_vld_q <= 1'b0;
         skid_dat_q <= '0;
         skid_err_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         main_dat_q <= main_dat_d;
         main_err_q <= main_err_d;
         skid_vld_q <= skid_vld_d;
         skid_dat_q <= skid_dat_d;
         skid_err_q <= skid_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign out_valid   = main_vld_q;
   assign out_data    = main_dat_q;
   assign out_sel_err = main_err_q;
   assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_vec_mux_pipe.sv
// Bench for vec_mux_pipe (K=3, M=4, N=8): queue-based reference model plus directed literal checks.
module tb_vec_mux_pipe;
   localparam int N  = 8;
   localparam int M  = 4;
   localparam int K  = 3;
   localparam int SW = 2;
   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [K*M*N-1:0] in_data;
   logic [SW-1:0]    in_sel;
   logic [M-1:0]     in_lane_mask;
   logic             out_valid;
   logic             out_ready;
   logic [M*N-1:0]   out_data;
   logic             out_sel_err;
   logic [CW-1:0]    err_count;

   always #5 clk = ~clk;

   vec_mux_pipe #(.N(N), .M(M), .K(K), .SW(SW), .CW(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_sel       (in_sel),
      .in_lane_mask (in_lane_mask),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_sel_err  (out_sel_err),
      .err_count    (err_count)
   );

   typedef struct {
      logic [M*N-1:0] d;
      logic           e;
   } exp_t;

   exp_t q[$];
   int   mcnt = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [K*M*N-1:0] d, input int sel, input logic [M-1:0] mask);
      exp_t r;
      r.d = '0;
      r.e = (sel >= K);
      if (!r.e) begin
         for (int m = 0; m < M; m++) begin
            if (mask[m]) r.d[m*N +: N] = d[sel*M*N + m*N +: N];
         end
      end
      return r;
   endfunction

   // Reference: the block is a 2-deep FIFO; ready while fewer than 2 are held.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mcnt = 0;
      end else begin
         bit   acc;
         bit   xf;
         exp_t r;
         acc = in_valid && (q.size() < 2);
         xf  = (q.size() > 0) && out_ready;
         r   = model(in_data, int'(in_sel), in_lane_mask);
         if (xf) void'(q.pop_front());
         if (acc) begin
            q.push_back(r);
            if (r.e && mcnt < CMAX) mcnt++;
         end
      end
   end

   always @(negedge clk) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      check("err_count", 64'(err_count), 64'(mcnt));
      if (q.size() > 0) begin
         check("out_data", 64'(out_data), 64'(q[0].d));
         check("out_sel_err", {63'd0, out_sel_err}, {63'd0, q[0].e});
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic rand_data();
      in_data = {$urandom, $urandom, $urandom};
   endtask

   logic [M*N-1:0] sweep_exp [3];
   logic [M*N-1:0] held;
   logic           rdy;
   int             sent;
   int             guard;
   int             accepts;

   initial begin
      sweep_exp[0] = 32'h11111111;
      sweep_exp[1] = 32'h22222222;
      sweep_exp[2] = 32'h33333333;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_sel = '0;
      in_lane_mask = '0;
      in_data = '0;
      out_ready = 1'b1;
      repeat (2) tick();
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_sel_err", {63'd0, out_sel_err}, 64'd0);
      check("rst_err_count", 64'(err_count), 64'd0);

      rst_n = 1'b1;
      tick();
      check("ready_after_rst", {63'd0, in_ready}, 64'd1);

      // Select sweep, one result per cycle.
      in_data = {32'h33333333, 32'h22222222, 32'h11111111};
      in_lane_mask = 4'hF;
      for (int s = 0; s < 3; s++) begin
         in_valid = 1'b1;
         in_sel = SW'(s);
         tick();
         check("sweep_valid", {63'd0, out_valid}, 64'd1);
         check("sweep_data", 64'(out_data), 64'(sweep_exp[s]));
         check("sweep_err", {63'd0, out_sel_err}, 64'd0);
      end
      in_valid = 1'b0;
      tick();

      in_valid = 1'b1;
      in_sel = 2'd1;
      in_lane_mask = 4'b0101;
      tick();
      check("mask_0101", 64'(out_data), 64'h00220022);
      in_valid = 1'b0;
      tick();

      in_valid = 1'b1;
      in_sel = 2'd3;
      in_lane_mask = 4'hF;
      tick();
      check("sel3_data", 64'(out_data), 64'd0);
      check("sel3_err", {63'd0, out_sel_err}, 64'd1);
      check("sel3_count", 64'(err_count), 64'd1);
      in_valid = 1'b0;
      tick();

      // Backpressure: two accepts fill main+skid, then stall.
      out_ready = 1'b0;
      in_valid = 1'b1;
      sent = 0;
      rand_data();
      in_sel = SW'(sent % 3);
      repeat (4) begin
         rdy = in_ready;
         tick();
         if (rdy) begin
            sent++;
            rand_data();
            in_sel = SW'(sent % 3);
         end
      end
      check("bp_accepts", 64'(sent), 64'd2);
      check("bp_ready_low", {63'd0, in_ready}, 64'd0);
      held = out_data;
      tick();
      check("bp_stable", 64'(out_data), 64'(held));
      out_ready = 1'b1;
      guard = 0;
      while (sent < 5 && guard < 20) begin
         rdy = in_ready;
         tick();
         guard++;
         if (rdy) begin
            sent++;
            rand_data();
            in_sel = SW'(sent % 3);
         end
      end
      in_valid = 1'b0;
      check("bp_all_sent", 64'(sent), 64'd5);
      guard = 0;
      while (out_valid && guard < 20) begin
         tick();
         guard++;
      end
      check("bp_drained", {63'd0, out_valid}, 64'd0);

      // Random valid/ready traffic.
      accepts = 0;
      guard = 0;
      while (accepts < 1000 && guard < 20000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_sel = SW'($urandom_range(0, 3));
         in_lane_mask = M'($urandom);
         rand_data();
         rdy = in_ready;
         tick();
         guard++;
         if (rdy && in_valid) accepts++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("rand_accepts", 64'(accepts), 64'd1000);
      repeat (3) tick();

      // Saturation.
      in_valid = 1'b1;
      in_sel = 2'd3;
      in_lane_mask = 4'hF;
      repeat (300) tick();
      in_valid = 1'b0;
      tick();
      check("sat_count", 64'(err_count), 64'd255);

      // Asynchronous reset with both entries full.
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_sel = 2'd3;
      tick();
      tick();
      in_valid = 1'b0;
      check("full_valid", {63'd0, out_valid}, 64'd1);
      check("full_ready", {63'd0, in_ready}, 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {63'd0, out_valid}, 64'd0);
      check("arst_count", 64'(err_count), 64'd0);
      check("arst_data", 64'(out_data), 64'd0);
      check("arst_ready", {63'd0, in_ready}, 64'd1);
      tick();
      rst_n = 1'b1;
      in_data = {32'h33333333, 32'h22222222, 32'h11111111};
      in_sel = 2'd1;
      in_lane_mask = 4'hF;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      check("post_rst_valid", {63'd0, out_valid}, 64'd1);
      check("post_rst_data", 64'(out_data), 64'h22222222);
      check("post_rst_err", {63'd0, out_sel_err}, 64'd0);
      check("post_rst_count", 64'(err_count), 64'd0);
      in_valid = 1'b0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
